// File: rtl/instruction_decode_buffer_if.sv
// instruction_decode_buffer_if: fetch-side and decode-side handshake bundle for the decode buffer.
`ifndef WORD_LEN
`define WORD_LEN 32
`endif
`ifndef SIGN_EXTEND_LEN
`define SIGN_EXTEND_LEN 16
`endif

interface instruction_decode_buffer_if #(
    parameter int WORD_LEN = `WORD_LEN,
    parameter int IMM_LEN = `SIGN_EXTEND_LEN
);
    logic fetchValid;
    logic fetchReady;
    logic [WORD_LEN-1:0] fetchInstruction;
    logic [WORD_LEN-1:0] fetchPc;
    logic decodeValid;
    logic decodeReady;
    logic [5:0] opcode;
    logic [4:0] rs;
    logic [4:0] rt;
    logic [4:0] rd;
    logic [4:0] shamt;
    logic [5:0] funct;
    logic [IMM_LEN-1:0] immediate;
    logic [25:0] jumpTarget;
    logic [WORD_LEN-1:0] pcPlus4;
    logic [31:0] decodedCount;

    modport slave (
        input fetchValid, fetchInstruction, fetchPc, decodeReady,
        output fetchReady, decodeValid, opcode, rs, rt, rd, shamt, funct,
        output immediate, jumpTarget, pcPlus4, decodedCount
    );

    modport master (
        output fetchValid, fetchInstruction, fetchPc, decodeReady,
        input fetchReady, decodeValid, opcode, rs, rt, rd, shamt, funct,
        input immediate, jumpTarget, pcPlus4, decodedCount
    );
endinterface

// File: rtl/instruction_decode_buffer.sv
// instruction_decode_buffer: two-entry skid buffer between fetch and decode that splits the head word into MIPS fields.
`ifndef WORD_LEN
`define WORD_LEN 32
`endif
`ifndef SIGN_EXTEND_LEN
`define SIGN_EXTEND_LEN 16
`endif

module instruction_decode_buffer #(
    parameter int WORD_LEN = `WORD_LEN,
    parameter int IMM_LEN = `SIGN_EXTEND_LEN
) (
    input logic clk,
    input logic rst_n,
    input logic flush,
    instruction_decode_buffer_if.slave bus
);
    typedef enum logic [1:0] {EMPTY, BUSY, FULL} stateType;

    stateType state, nextState;
    logic [WORD_LEN-1:0] headInstr, headPc, skidInstr, skidPc;
    logic fetchReadyReg;
    logic [31:0] countReg;
    logic accept, deliver, loadHead, loadSkid, moveSkid;

    assign accept = bus.fetchValid && fetchReadyReg;
    assign deliver = bus.decodeValid && bus.decodeReady;

    always_comb begin
        nextState = state;
        loadHead = 1'b0;
        loadSkid = 1'b0;
        moveSkid = 1'b0;
        if (flush) nextState = EMPTY;
        else begin
            case (state)
                EMPTY: if (accept) begin
                    nextState = BUSY;
                    loadHead = 1'b1;
                end
                BUSY: if (accept && deliver) loadHead = 1'b1;
                else if (accept) begin
                    nextState = FULL;
                    loadSkid = 1'b1;
                end else if (deliver) nextState = EMPTY;
                FULL: if (deliver) begin
                    nextState = BUSY;
                    moveSkid = 1'b1;
                end
                default: nextState = EMPTY;
            endcase
        end
    end

    // ready is registered from the next state so decodeReady never reaches fetchReady combinationally
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= EMPTY;
            fetchReadyReg <= 1'b1;
            countReg <= '0;
        end else begin
            state <= nextState;
            fetchReadyReg <= nextState != FULL;
            if (deliver) countReg <= countReg + 32'd1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            headInstr <= '0;
            headPc <= '0;
            skidInstr <= '0;
            skidPc <= '0;
        end else begin
            if (loadHead) begin
                headInstr <= bus.fetchInstruction;
                headPc <= bus.fetchPc;
            end else if (moveSkid) begin
                headInstr <= skidInstr;
                headPc <= skidPc;
            end
            if (loadSkid) begin
                skidInstr <= bus.fetchInstruction;
                skidPc <= bus.fetchPc;
            end
        end
    end

    assign bus.fetchReady = fetchReadyReg;
    assign bus.decodeValid = state != EMPTY;
    assign bus.opcode = headInstr[31:26];
    assign bus.rs = headInstr[25:21];
    assign bus.rt = headInstr[20:16];
    assign bus.rd = headInstr[15:11];
    assign bus.shamt = headInstr[10:6];
    assign bus.funct = headInstr[5:0];
    assign bus.immediate = headInstr[IMM_LEN-1:0];
    assign bus.jumpTarget = headInstr[25:0];
    assign bus.pcPlus4 = headPc + WORD_LEN'(4);
    assign bus.decodedCount = countReg;
endmodule

// File: tb/tb_instruction_decode_buffer.sv
// tb_instruction_decode_buffer: scoreboard bench for the decode skid buffer with directed vectors.
module tb_instruction_decode_buffer;
    logic clk = 1'b0;
    logic rst_n;
    logic flush;
    int checks = 0;
    int errors = 0;

    typedef struct {
        logic [5:0] op;
        logic [4:0] rs, rt, rd, sh;
        logic [5:0] fn;
        logic [15:0] imm;
        logic [25:0] jt;
        logic [31:0] pc4;
    } expType;

    expType q[$];
    expType e;

    instruction_decode_buffer_if bus ();

    instruction_decode_buffer dut (
        .clk(clk),
        .rst_n(rst_n),
        .flush(flush),
        .bus(bus)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic pushExp(input logic [5:0] op, input logic [4:0] rs, input logic [4:0] rt,
                           input logic [4:0] rd, input logic [4:0] sh, input logic [5:0] fn,
                           input logic [15:0] imm, input logic [25:0] jt, input logic [31:0] pc4);
        expType x;
        x.op = op; x.rs = rs; x.rt = rt; x.rd = rd; x.sh = sh;
        x.fn = fn; x.imm = imm; x.jt = jt; x.pc4 = pc4;
        q.push_back(x);
    endtask

    task automatic waitAccept();
        int n = 0;
        while (!bus.fetchReady && n < 50) begin
            step();
            n++;
        end
        if (!bus.fetchReady) begin
            checks++;
            errors++;
            $display("FAIL accept_timeout: got fetchReady 0 expected 1 within 50 cycles");
        end
        step();
        bus.fetchValid = 1'b0;
    endtask

    task automatic send(input logic [31:0] ins, input logic [31:0] pc);
        bus.fetchValid = 1'b1;
        bus.fetchInstruction = ins;
        bus.fetchPc = pc;
        waitAccept();
    endtask

    always @(negedge clk) begin
        if (rst_n && bus.decodeValid && bus.decodeReady) begin
            if (q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_output: got opcode %h imm %h pcPlus4 %h expected no output",
                         bus.opcode, bus.immediate, bus.pcPlus4);
            end else begin
                e = q.pop_front();
                chk("opcode", 32'(bus.opcode), 32'(e.op));
                chk("rs", 32'(bus.rs), 32'(e.rs));
                chk("rt", 32'(bus.rt), 32'(e.rt));
                chk("rd", 32'(bus.rd), 32'(e.rd));
                chk("shamt", 32'(bus.shamt), 32'(e.sh));
                chk("funct", 32'(bus.funct), 32'(e.fn));
                chk("immediate", 32'(bus.immediate), 32'(e.imm));
                chk("jumpTarget", 32'(bus.jumpTarget), 32'(e.jt));
                chk("pcPlus4", bus.pcPlus4, e.pc4);
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got no finish expected finish before 200us");
        $fatal(1, "watchdog");
    end

    initial begin
        rst_n = 1'b0;
        flush = 1'b0;
        bus.fetchValid = 1'b0;
        bus.fetchInstruction = '0;
        bus.fetchPc = '0;
        bus.decodeReady = 1'b0;
        step();
        step();
        chk("rst_fetchReady", 32'(bus.fetchReady), 1);
        chk("rst_decodeValid", 32'(bus.decodeValid), 0);
        chk("rst_immediate", 32'(bus.immediate), 0);
        chk("rst_opcode", 32'(bus.opcode), 0);
        chk("rst_pcPlus4", bus.pcPlus4, 32'h4);
        chk("rst_count", bus.decodedCount, 0);
        rst_n = 1'b1;
        step();

        // single pass
        bus.decodeReady = 1'b1;
        pushExp(6'h08, 5'd8, 5'd8, 5'd16, 5'd0, 6'h00, 16'h8000, 26'h1088000, 32'h0040_0004);
        send(32'h2108_8000, 32'h0040_0000);
        chk("single_latency_valid", 32'(bus.decodeValid), 1);
        step();
        chk("single_count", bus.decodedCount, 1);
        chk("single_drained", 32'(bus.decodeValid), 0);

        // back-pressure into the skid entry
        pushExp(6'h08, 5'd0, 5'd8, 5'd15, 5'd31, 6'h3F, 16'h7FFF, 26'h0087FFF, 32'h0000_0104);
        pushExp(6'h08, 5'd0, 5'd9, 5'd16, 5'd0, 6'h00, 16'h8000, 26'h0098000, 32'h0000_0108);
        pushExp(6'h08, 5'd0, 5'd10, 5'd0, 5'd0, 6'h01, 16'h0001, 26'h00A0001, 32'h0000_010C);
        send(32'h2008_7FFF, 32'h0000_0100);
        bus.decodeReady = 1'b0;
        send(32'h2009_8000, 32'h0000_0104);
        chk("bp_full_fetchReady", 32'(bus.fetchReady), 0);
        chk("bp_full_decodeValid", 32'(bus.decodeValid), 1);
        bus.fetchValid = 1'b1;
        bus.fetchInstruction = 32'h200A_0001;
        bus.fetchPc = 32'h0000_0108;
        step();
        step();
        chk("bp_hold_fetchReady", 32'(bus.fetchReady), 0);
        chk("bp_hold_immediate", 32'(bus.immediate), 32'h7FFF);
        chk("bp_hold_pcPlus4", bus.pcPlus4, 32'h0000_0104);
        bus.decodeReady = 1'b1;
        waitAccept();
        repeat (3) step();
        chk("bp_count", bus.decodedCount, 4);
        chk("bp_no_loss", 32'(q.size()), 0);
        chk("bp_drained", 32'(bus.decodeValid), 0);

        // flush while full with a simultaneous offer
        bus.decodeReady = 1'b0;
        send(32'h3C01_FFFF, 32'h0000_0500);
        send(32'h3C02_1234, 32'h0000_0504);
        chk("fl_full_fetchReady", 32'(bus.fetchReady), 0);
        bus.fetchValid = 1'b1;
        bus.fetchInstruction = 32'h3C03_5678;
        bus.fetchPc = 32'h0000_0508;
        flush = 1'b1;
        step();
        flush = 1'b0;
        bus.fetchValid = 1'b0;
        chk("fl_decodeValid", 32'(bus.decodeValid), 0);
        chk("fl_fetchReady", 32'(bus.fetchReady), 1);
        bus.decodeReady = 1'b1;
        repeat (3) step();
        chk("fl_count", bus.decodedCount, 4);

        // PC and count wrap
        pushExp(6'h23, 5'd0, 5'd0, 5'd0, 5'd0, 6'h10, 16'h0010, 26'h0000010, 32'h0000_0000);
        send(32'h8C00_0010, 32'hFFFF_FFFC);
        chk("wrap_pcPlus4", bus.pcPlus4, 32'h0000_0000);
        step();
        chk("wrap_count5", bus.decodedCount, 5);
        force dut.countReg = 32'hFFFF_FFFF;
        step();
        release dut.countReg;
        chk("wrap_preload", bus.decodedCount, 32'hFFFF_FFFF);
        pushExp(6'h00, 5'd0, 5'd0, 5'd0, 5'd0, 6'h00, 16'h0000, 26'h0000000, 32'h0000_0204);
        send(32'h0000_0000, 32'h0000_0200);
        step();
        chk("wrap_count0", bus.decodedCount, 0);

        // async reset mid-stream while full
        bus.decodeReady = 1'b0;
        send(32'h3C04_AAAA, 32'h0000_0600);
        send(32'h3C05_BBBB, 32'h0000_0604);
        chk("ar_full_fetchReady", 32'(bus.fetchReady), 0);
        #2;
        rst_n = 1'b0;
        #1;
        chk("ar_decodeValid", 32'(bus.decodeValid), 0);
        chk("ar_fetchReady", 32'(bus.fetchReady), 1);
        chk("ar_immediate", 32'(bus.immediate), 0);
        chk("ar_pcPlus4", bus.pcPlus4, 32'h4);
        chk("ar_count", bus.decodedCount, 0);
        step();
        rst_n = 1'b1;
        bus.decodeReady = 1'b1;
        pushExp(6'h00, 5'd9, 5'd10, 5'd8, 5'd0, 6'h20, 16'h4020, 26'h12A4020, 32'h0000_0304);
        send(32'h012A_4020, 32'h0000_0300);
        chk("ar_latency_valid", 32'(bus.decodeValid), 1);
        step();
        chk("ar_count_after", bus.decodedCount, 1);
        chk("final_no_loss", 32'(q.size()), 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule

// File: doc/instruction_decode_buffer.md
# instruction_decode_buffer

- Sits between the instruction fetch stage and decode.
- Registers each fetched instruction and its PC in a two-entry skid buffer with valid/ready handshakes on both sides.
- Splits the held instruction into MIPS fields. Its 16-bit `immediate` output drives the sign-extension unit's `inputSignalBeforeExtension` directly.
- Absorbs one cycle of downstream back-pressure without a combinational ready path, and supports a synchronous pipeline flush.

## Interface
Parameters:
- `WORD_LEN`, default `` `WORD_LEN `` (32): instruction and PC width.
- `IMM_LEN`, default `` `SIGN_EXTEND_LEN `` (16): immediate field width.

Ports:
- `clk`  in  1  sole clock; all state updates on the rising edge.
- `rst_n`  in  1  reset, asynchronous, active-low.
- `flush`  in  1  synchronous discard of all buffered instructions.
- `fetchValid`  in  1  fetch offers an instruction this cycle.
- `fetchReady`  out  1  buffer can accept; driven from a register.
- `fetchInstruction`  in  WORD_LEN  instruction word.
- `fetchPc`  in  WORD_LEN  address of `fetchInstruction`.
- `decodeValid`  out  1  head entry valid.
- `decodeReady`  in  1  decode consumes the head this cycle.
- `opcode`  out  6  head instruction bits [31:26].
- `rs`  out  5  head instruction bits [25:21].
- `rt`  out  5  head instruction bits [20:16].
- `rd`  out  5  head instruction bits [15:11].
- `shamt`  out  5  head instruction bits [10:6].
- `funct`  out  6  head instruction bits [5:0].
- `immediate`  out  IMM_LEN  head instruction bits [15:0]; feeds the sign extender.
- `jumpTarget`  out  26  head instruction bits [25:0].
- `pcPlus4`  out  WORD_LEN  head PC + 4.
- `decodedCount`  out  32  number of output handshakes since reset.

## Operation
Handshakes:
- Accept: `fetchValid && fetchReady`.
- Deliver: `decodeValid && decodeReady`.

Storage and outputs:
- Storage is a head register (instruction + PC) and a skid register.
- All field outputs and `pcPlus4` are combinational slices of the head register.

FSM states:
- EMPTY: head invalid, skid invalid.
- BUSY: head valid, skid invalid.
- FULL: head valid, skid valid.

Transitions (flush not asserted):
- EMPTY + accept → BUSY; input loads head.
- BUSY + accept + deliver → BUSY; input loads head.
- BUSY + accept, no deliver → FULL; input loads skid.
- BUSY + deliver, no accept → EMPTY.
- FULL + deliver → BUSY; skid moves to head, skid cleared. Accept is impossible in FULL.
- Any other combination holds state and contents.

Ready and ordering:
- `fetchReady` next value = 1 unless the next state is FULL.
- Instructions leave in acceptance order. There is no duplication and no loss.

Flush:
- Highest priority. Next state is EMPTY and `fetchReady` goes to 1.
- An instruction accepted in the flush cycle is discarded.
- A delivery in the flush cycle still counts, because downstream consumed it.

Arithmetic and content rules:
- `pcPlus4` is computed modulo 2^WORD_LEN: 0xFFFFFFFC gives 0x00000000.
- `decodedCount` increments by 1 per delivery and wraps from 0xFFFFFFFF to 0.
- Head and skid data registers load only on accept or skid-to-head move. They are not cleared on flush: `decodeValid` = 0 qualifies them.

## Timing
Reset:
- Asserting `rst_n` = 0 immediately forces state EMPTY, `fetchReady` = 1, `decodeValid` = 0, head/skid data = 0, and `decodedCount` = 0.
- Consequently every field output, `immediate` and `jumpTarget` read 0, and `pcPlus4` reads 4.
- Reset mid-operation discards all entries.

Latency:
- Accept in cycle N from EMPTY or draining BUSY → `decodeValid` = 1 with the new fields in cycle N+1.

Throughput and back-pressure:
- Throughput is one instruction per cycle while `decodeReady` = 1.
- When `decodeReady` drops, at most one further instruction is accepted: the one in flight into skid.
- `fetchReady` falls the following cycle.
- On the first cycle `decodeReady` returns, the head is delivered. `fetchReady` rises the cycle after.

Combinational paths:
- None from `decodeReady` to `fetchReady`.
- Field outputs change only after a clock edge.

## Test plan
- Reset: hold `rst_n` = 0 → `fetchReady` = 1, `decodeValid` = 0, `immediate` = 0x0000, `pcPlus4` = 0x00000004, `decodedCount` = 0.
- Single pass: accept 0x2108_8000 at PC 0x00400000 with `decodeReady` = 1 → next cycle `opcode` = 0x08, `rs` = 8, `rt` = 8, `immediate` = 0x8000, `pcPlus4` = 0x00400004; `decodedCount` = 1 after delivery.
- Back-pressure: stream 0x20087FFF, 0x20098000, 0x200A0001 with `decodeReady` = 0 from the second cycle → state FULL, `fetchReady` = 0. After `decodeReady` = 1, outputs arrive in order with `immediate` = 0x7FFF, 0x8000, 0x0001 and no loss.
- Flush while FULL plus simultaneous `fetchValid` → next cycle `decodeValid` = 0, `fetchReady` = 1. The flushed and incoming instructions never appear at the output.
- Wrap: accept at PC 0xFFFFFFFC → `pcPlus4` = 0x00000000. Preload `decodedCount` by 2^32−1 deliveries (or force) → the next delivery yields 0.
- Async reset asserted mid-stream in FULL, between clock edges → outputs reach reset values before the next edge. The first accept after release appears with 1-cycle latency.
